// File: rtl/pdn_pkg.sv
// Shared definitions for the permutation deflection network: flit layout,
// direction codes and the injector state encoding.
package pdn_pkg;

    localparam int FLIT_W    = 10;
    localparam int VALID_BIT = 9;
    localparam int DX_MSB    = 8;
    localparam int DX_LSB    = 7;
    localparam int DY_MSB    = 6;
    localparam int DY_LSB    = 5;
    localparam int PL_MSB    = 4;
    localparam int PL_LSB    = 0;

    localparam logic [1:0] DIR_E = 2'd0;
    localparam logic [1:0] DIR_W = 2'd1;
    localparam logic [1:0] DIR_N = 2'd2;
    localparam logic [1:0] DIR_S = 2'd3;

    typedef logic [FLIT_W-1:0] flit_t;

    // Queue entry: a flit without its valid bit.
    typedef struct packed {
        logic [1:0] dst_x;
        logic [1:0] dst_y;
        logic [4:0] payload;
    } inj_req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STARVE = 2'd2
    } inj_state_e;

endpackage

// File: rtl/pdn_injector_if.sv
// Core-to-injector request channel: valid/ready handshake carrying the
// destination coordinates and payload.
interface pdn_injector_if;

    logic       core_valid;
    logic       core_ready;
    logic [1:0] core_dst_x;
    logic [1:0] core_dst_y;
    logic [4:0] core_payload;

    modport master (
        output core_valid, core_dst_x, core_dst_y, core_payload,
        input  core_ready
    );

    modport slave (
        input  core_valid, core_dst_x, core_dst_y, core_payload,
        output core_ready
    );

endinterface

// File: rtl/pdn_inj_fifo.sv
// Synchronous injection queue; push is ignored when full and pop when empty,
// so the head is always presented combinationally on pop_data.
module pdn_inj_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign level    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: clearing the pointers already discards contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/pdn_injector.sv
// Node-side transmit end of the deflection network: filters self-addressed
// requests, queues the rest and injects one flit whenever the router has a slot.
module pdn_injector
    import pdn_pkg::*;
#(
    parameter logic [1:0] MY_X         = 2'd0,
    parameter logic [1:0] MY_Y         = 2'd0,
    parameter int         DEPTH        = 4,
    parameter int         STARVE_LIMIT = 8,
    parameter int         CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pdn_injector_if.slave          core,
    input  logic                   slot_free,
    output logic [FLIT_W-1:0]      inj_flit,
    output logic                   starve,
    output logic                   self_drop,
    output logic [CNT_W-1:0]       inj_count,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int WC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_WAIT   = ST_WAIT;
    localparam logic [1:0] S_STARVE = ST_STARVE;

    logic             rdy_q, rdy_d;
    flit_t            inj_flit_q, inj_flit_d;
    logic             self_drop_q, self_drop_d;
    logic             starve_q, starve_d;
    logic [CNT_W-1:0] inj_count_q, inj_count_d;
    logic [1:0]       state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic             accept, is_self, push, pop;
    logic             full, empty;
    logic [LVL_W-1:0] level;
    inj_req_t         req, head;

    assign req       = '{dst_x: core.core_dst_x, dst_y: core.core_dst_y,
                         payload: core.core_payload};
    assign accept    = core.core_valid & core.core_ready;
    assign is_self   = (core.core_dst_x == MY_X) && (core.core_dst_y == MY_Y);
    assign push      = accept & ~is_self;
    assign pop       = ~empty & slot_free;

    // Ready is held low through reset and the first edge after it.
    assign core.core_ready = rdy_q & ~full;

    assign inj_flit   = inj_flit_q;
    assign starve     = starve_q;
    assign self_drop  = self_drop_q;
    assign inj_count  = inj_count_q;
    assign fifo_level = level;

    pdn_inj_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(inj_req_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (req),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    always_comb begin
        rdy_d       = 1'b1;
        self_drop_d = accept & is_self;
        inj_count_d = inj_count_q + CNT_W'(pop);
        inj_flit_d  = '0;
        if (pop) begin
            inj_flit_d[VALID_BIT]     = 1'b1;
            inj_flit_d[DX_MSB:DX_LSB] = head.dst_x;
            inj_flit_d[DY_MSB:DY_LSB] = head.dst_y;
            inj_flit_d[PL_MSB:PL_LSB] = head.payload;
        end
    end

    // Starvation tracking: count blocked cycles while entries wait for a slot.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (push) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT, S_STARVE: begin
                if (pop) begin
                    wait_cnt_d = '0;
                    state_d    = (level == LVL_W'(1) && !push) ? S_IDLE : S_WAIT;
                end else if (state_q == S_WAIT && !slot_free) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_d == WC_W'(STARVE_LIMIT)) begin
                        state_d = S_STARVE;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = '0;
            end
        endcase
        starve_d = (state_d == S_STARVE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            inj_flit_q  <= '0;
            self_drop_q <= 1'b0;
            starve_q    <= 1'b0;
            inj_count_q <= '0;
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
        end else begin
            rdy_q       <= rdy_d;
            inj_flit_q  <= inj_flit_d;
            self_drop_q <= self_drop_d;
            starve_q    <= starve_d;
            inj_count_q <= inj_count_d;
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_pdn_injector.sv
// Scoreboard bench for pdn_injector: expected flits are queued at acceptance
// and a negedge monitor compares every valid flit against the queue head.
module tb_pdn_injector;

    logic       clk;
    logic       rst_n;
    logic       slot_free;
    logic [9:0] inj_flit;
    logic       starve;
    logic       self_drop;
    logic [3:0] inj_count;
    logic [2:0] fifo_level;

    int         checks;
    int         errors;
    logic [9:0] exp_q[$];

    pdn_injector_if core_if ();

    pdn_injector #(
        .MY_X         (2'd0),
        .MY_Y         (2'd0),
        .DEPTH        (4),
        .STARVE_LIMIT (8),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core       (core_if),
        .slot_free  (slot_free),
        .inj_flit   (inj_flit),
        .starve     (starve),
        .self_drop  (self_drop),
        .inj_count  (inj_count),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and waits (bounded) for it to be accepted.
    task automatic apply_stimulus(input logic [1:0] dx, input logic [1:0] dy, input logic [4:0] pl);
        int budget;
        budget = 50;
        core_if.core_valid   = 1'b1;
        core_if.core_dst_x   = dx;
        core_if.core_dst_y   = dy;
        core_if.core_payload = pl;
        while (!core_if.core_ready && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=not_ready required=ready");
        end else begin
            if (!(dx == 2'd0 && dy == 2'd0)) begin
                exp_q.push_back({1'b1, dx, dy, pl});
            end
            tick();
        end
        core_if.core_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && inj_flit[9]) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_flit actual=%0h required=none", inj_flit);
            end else begin
                check_output("flit_order", inj_flit, exp_q.pop_front());
            end
        end
    end

    initial begin
        checks               = 0;
        errors               = 0;
        rst_n                = 1'b0;
        slot_free            = 1'b0;
        core_if.core_valid   = 1'b0;
        core_if.core_dst_x   = 2'd0;
        core_if.core_dst_y   = 2'd0;
        core_if.core_payload = 5'd0;
        #2;
        check_output("rst_inj_flit", inj_flit, 0);
        check_output("rst_core_ready", core_if.core_ready, 0);
        check_output("rst_level", fifo_level, 0);
        check_output("rst_starve", starve, 0);
        check_output("rst_count", inj_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_output("ready_after_rst", core_if.core_ready, 1);

        // Test 1: two-cycle latency to the router.
        slot_free = 1'b1;
        apply_stimulus(2'd1, 2'd2, 5'h15);
        check_output("lat_not_early", inj_flit, 0);
        tick();
        check_output("lat_flit", inj_flit, 10'b1_01_10_10101);
        check_output("lat_count", inj_count, 1);
        tick();

        // Test 2: blocked queue fills, starves, then drains in order.
        slot_free = 1'b0;
        apply_stimulus(2'd1, 2'd0, 5'h01);
        apply_stimulus(2'd2, 2'd1, 5'h02);
        apply_stimulus(2'd3, 2'd2, 5'h03);
        apply_stimulus(2'd0, 2'd3, 5'h04);
        check_output("full_level", fifo_level, 4);
        check_output("full_ready", core_if.core_ready, 0);
        for (int i = 0; i < 4; i++) tick();
        check_output("starve_before_limit", starve, 0);
        tick();
        check_output("starve_at_limit", starve, 1);
        slot_free = 1'b1;
        tick();
        check_output("starve_clear", starve, 0);
        check_output("drain_level", fifo_level, 3);
        for (int i = 0; i < 4; i++) tick();
        check_output("drained_level", fifo_level, 0);

        // Test 3: self-addressed request is dropped.
        apply_stimulus(2'd0, 2'd0, 5'h0A);
        check_output("self_drop_pulse", self_drop, 1);
        check_output("self_level", fifo_level, 0);
        tick();
        check_output("self_drop_end", self_drop, 0);
        check_output("self_no_flit", inj_flit, 0);

        // Test 4: simultaneous push and pop hold the level.
        slot_free = 1'b0;
        apply_stimulus(2'd1, 2'd1, 5'h11);
        apply_stimulus(2'd2, 2'd2, 5'h12);
        check_output("pp_level_before", fifo_level, 2);
        slot_free = 1'b1;
        apply_stimulus(2'd3, 2'd3, 5'h13);
        check_output("pp_level_same", fifo_level, 2);
        for (int i = 0; i < 3; i++) tick();
        check_output("pp_drained", fifo_level, 0);

        // Test 5: asynchronous reset with three queued and starve raised.
        slot_free = 1'b0;
        apply_stimulus(2'd1, 2'd3, 5'h1D);
        apply_stimulus(2'd3, 2'd1, 5'h1E);
        apply_stimulus(2'd2, 2'd3, 5'h1F);
        for (int i = 0; i < 6; i++) tick();
        check_output("pre_rst_starve", starve, 1);
        check_output("pre_rst_level", fifo_level, 3);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_output("async_inj_flit", inj_flit, 0);
        check_output("async_level", fifo_level, 0);
        check_output("async_starve", starve, 0);
        check_output("async_ready", core_if.core_ready, 0);
        tick();
        #2;
        rst_n = 1'b1;
        #1;
        check_output("ready_low_until_edge", core_if.core_ready, 0);
        tick();
        check_output("ready_after_edge", core_if.core_ready, 1);

        // Test 6: counter wraps after 17 flits with a 4-bit counter.
        check_output("count_zero", inj_count, 0);
        slot_free = 1'b1;
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(2'd1, 2'd1, 5'(i));
        end
        tick();
        tick();
        check_output("count_wrap", inj_count, 1);
        check_output("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
